// File: rtl/ecs3_pkg.sv
// ecs3_pkg: shared states, line constant and frame-length helper for the ECS3 transceiver
package ecs3_pkg;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    localparam logic LINE_IDLE = 1'b1;
    function automatic int ecs3_nbits(input int data_w, input int parity_en);
        return data_w + 2 + ((parity_en != 0) ? 1 : 0);
    endfunction
endpackage

// File: rtl/ecs3_sync_fifo.sv
// ecs3_sync_fifo: single-clock show-ahead FIFO with occupancy output
module ecs3_sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          nRST,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic push, pull;
    assign full    = level == (AW+1)'(FIFO_DEPTH);
    assign empty   = level == '0;
    assign push    = wr_en && !full;
    assign pull    = rd_en && !empty;
    assign rd_data = mem[rp];
    // storage array, written only when there is room
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wr_data;
    end
    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pull) rp <= rp + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pull);
        end
    end
endmodule

// File: rtl/ecs3_transceiver_p.sv
// ecs3_transceiver_p: parametrised ECS3 serial TX/RX pair with TX FIFO, parity, glitch rejection and loopback
module ecs3_transceiver_p
    import ecs3_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DIV        = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic                          clk,
    input  logic                          nRST,
    input  logic                          TXValid,
    output logic                          TXReady,
    input  logic [DATA_W-1:0]             TXData_In,
    output logic [$clog2(FIFO_DEPTH):0]   TXLevel,
    output logic                          TXBusy,
    output logic                          TXSelect,
    output logic                          RXSelect,
    output logic                          ECS3_Out,
    input  logic                          Loopback,
    input  logic                          ECS3_In,
    output logic                          RXValid,
    output logic [DATA_W-1:0]             RXData_Out,
    output logic                          RXParityErr,
    output logic                          RXFrameErr
);
    localparam int NBITS = ecs3_nbits(DATA_W, PARITY_EN);
    localparam int BW    = $clog2(NBITS);
    localparam int TW    = $clog2(DIV);

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic [TW-1:0] tcnt, rcnt;
    logic [BW-1:0] tbit, rbit;
    logic [DATA_W-1:0] tshift, rshift, fifo_q;
    logic tpar, rpar, tx_line, pop, empty, full, tick, sample, s1, s2, s3, fall, line;

    ecs3_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .nRST(nRST), .wr_en(TXValid), .wr_data(TXData_In), .rd_en(pop),
        .rd_data(fifo_q), .full(full), .empty(empty), .level(TXLevel)
    );

    assign tick     = tcnt == TW'(DIV-1);
    assign TXReady  = !full;
    assign TXSelect = tx_state != TX_IDLE;
    assign TXBusy   = TXSelect;
    assign RXSelect = !TXSelect;
    assign tx_line  = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tshift[DATA_W-1] :
                      tx_state == TX_PARITY ? tpar : LINE_IDLE;
    assign ECS3_Out = Loopback ? LINE_IDLE : tx_line;
    assign line     = Loopback ? tx_line : ECS3_In;
    assign fall     = s3 && !s2;
    assign sample   = rx_state == RX_START ? rcnt == TW'(DIV/2) : rcnt == TW'(DIV-1);

    // TX next state; a word is popped whenever a new frame begins
    always_comb begin
        tx_next = tx_state;
        pop     = 1'b0;
        case (tx_state)
            TX_IDLE:   if (!empty) begin tx_next = TX_START; pop = 1'b1; end
            TX_START:  if (tick) tx_next = TX_DATA;
            TX_DATA:   if (tick && tbit == BW'(DATA_W)) tx_next = PARITY_EN != 0 ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tick) tx_next = TX_STOP;
            TX_STOP:   if (tick) begin tx_next = empty ? TX_IDLE : TX_START; pop = !empty; end
            default:   tx_next = TX_IDLE;
        endcase
    end

    // RX next state; a high start-bit sample is treated as a glitch
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (fall) rx_next = RX_START;
            RX_START:  if (sample) rx_next = s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (sample && rbit == BW'(DATA_W)) rx_next = PARITY_EN != 0 ? RX_PARITY : RX_STOP;
            RX_PARITY: if (sample) rx_next = RX_STOP;
            RX_STOP:   if (sample) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    // TX state, bit timer, frame bit index and shift register
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            tx_state <= TX_IDLE;
            tcnt     <= '0;
            tbit     <= '0;
            tshift   <= '0;
            tpar     <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tcnt     <= (tx_state == TX_IDLE || tick) ? '0 : tcnt + 1'b1;
            tbit     <= (tx_state == TX_IDLE || pop) ? '0 : tick ? tbit + 1'b1 : tbit;
            if (pop) begin
                tshift <= fifo_q;
                tpar   <= ^fifo_q;
            end else if (tx_state == TX_DATA && tick) begin
                tshift <= tshift << 1;
            end
        end
    end

    // RX synchroniser, mid-bit sampler and registered result/flags
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            {s1, s2, s3} <= 3'b111;
            rx_state     <= RX_IDLE;
            rcnt         <= '0;
            rbit         <= '0;
            rshift       <= '0;
            rpar         <= 1'b0;
            RXValid      <= 1'b0;
            RXData_Out   <= '0;
            RXParityErr  <= 1'b0;
            RXFrameErr   <= 1'b0;
        end else begin
            {s1, s2, s3} <= {line, s1, s2};
            rx_state     <= rx_next;
            rcnt         <= (rx_state == RX_IDLE || sample) ? '0 : rcnt + 1'b1;
            rbit         <= rx_state == RX_IDLE ? '0 : sample ? rbit + 1'b1 : rbit;
            if (rx_state == RX_DATA && sample) rshift <= (rshift << 1) | DATA_W'(s2);
            if (rx_state == RX_PARITY && sample) rpar <= s2;
            RXValid     <= rx_state == RX_STOP && sample;
            RXParityErr <= rx_state == RX_STOP && sample && PARITY_EN != 0 && ((^rshift) != rpar);
            RXFrameErr  <= rx_state == RX_STOP && sample && !s2;
            if (rx_state == RX_STOP && sample) RXData_Out <= rshift;
        end
    end
endmodule

// File: tb/tb_ecs3_transceiver_p.sv
// tb_ecs3_transceiver_p: directed scoreboard bench for the ECS3 transceiver
module tb_ecs3_transceiver_p;
    import ecs3_pkg::*;
    localparam int DW = 16;
    localparam int DIV = 8;

    typedef struct packed {logic [DW-1:0] d; logic pe; logic fe;} exp_t;

    logic clk = 1'b0, nRST = 1'b0, TXValid = 1'b0, Loopback = 1'b0, ECS3_In = 1'b1;
    logic [DW-1:0] TXData_In = '0;
    logic TXReady, TXBusy, TXSelect, RXSelect, ECS3_Out, RXValid, RXParityErr, RXFrameErr;
    logic [2:0] TXLevel;
    logic [DW-1:0] RXData_Out;

    int errors = 0, checks = 0, cyc = 0, rx_count = 0, last_rx = 0, out_bad = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    ecs3_transceiver_p #(.DATA_W(DW), .DIV(DIV), .FIFO_DEPTH(4), .PARITY_EN(1)) dut (
        .clk(clk), .nRST(nRST), .TXValid(TXValid), .TXReady(TXReady), .TXData_In(TXData_In),
        .TXLevel(TXLevel), .TXBusy(TXBusy), .TXSelect(TXSelect), .RXSelect(RXSelect),
        .ECS3_Out(ECS3_Out), .Loopback(Loopback), .ECS3_In(ECS3_In), .RXValid(RXValid),
        .RXData_Out(RXData_Out), .RXParityErr(RXParityErr), .RXFrameErr(RXFrameErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: each received word is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (Loopback && ECS3_Out !== 1'b1) out_bad++;
        if (prev_valid) check("flags_clear", {30'b0, RXParityErr, RXFrameErr}, 0);
        prev_valid = nRST && RXValid === 1'b1;
        if (nRST && RXValid === 1'b1) begin
            rx_count++;
            last_rx = cyc;
            check("rx_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rx_data", RXData_Out, e.d);
                check("rx_perr", RXParityErr, e.pe);
                check("rx_ferr", RXFrameErr, e.fe);
            end
        end
    end

    task automatic wait_rx(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        check("rx_drain", sb.size(), 0);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
        logic [DW+2:0] f;
        f = {1'b0, d, p, s};
        for (int i = DW + 2; i >= 0; i--) begin
            ECS3_In = f[i];
            repeat (DIV) @(negedge clk);
        end
        ECS3_In = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] w [6];
        int acc [6];
        int idx, t0, t_rise, rxc;
        logic rdy, rose;
        w = '{16'h0001, 16'h8000, 16'hFFFE, 16'h3C3C, 16'h7E81, 16'hDEAD};

        repeat (3) @(negedge clk);
        check("rst_out", ECS3_Out, 1);
        check("rst_txsel", TXSelect, 0);
        check("rst_rxsel", RXSelect, 1);
        check("rst_busy", TXBusy, 0);
        check("rst_level", TXLevel, 0);
        check("rst_ready", TXReady, 1);
        check("rst_valid", RXValid, 0);
        check("rst_data", RXData_Out, 0);
        check("rst_flags", {RXParityErr, RXFrameErr}, 0);
        nRST = 1'b1;
        Loopback = 1'b1;
        repeat (2) @(negedge clk);

        // single loopback word
        TXData_In = 16'hA5C3;
        TXValid = 1'b1;
        sb.push_back('{16'hA5C3, 1'b0, 1'b0});
        @(negedge clk);
        TXValid = 1'b0;
        t0 = cyc;
        check("lvl_after_write", TXLevel, 1);
        check("txsel_before", TXSelect, 0);
        @(negedge clk);
        check("txsel_start", TXSelect, 1);
        check("busy_start", TXBusy, 1);
        check("rxsel_start", RXSelect, 0);
        check("line_start", dut.tx_line, 0);
        check("lvl_popped", TXLevel, 0);
        repeat (136) @(negedge clk);
        check("parity_bit", dut.tx_line, 0);
        wait_rx(300);
        check("rx_latency", last_rx - t0, 153);
        check("out_idle_lb", out_bad, 0);
        repeat (4) @(negedge clk);

        // held TXValid, six words, FIFO fills and back-pressures
        idx = 0;
        rose = 1'b0;
        t_rise = 0;
        TXValid = 1'b1;
        for (int c = 0; c < 400 && idx < 6; c++) begin
            TXData_In = w[idx];
            rdy = TXReady;
            if (TXLevel == 3'd4) check("ready_full", TXReady, 0);
            @(negedge clk);
            if (rdy) begin
                acc[idx] = cyc;
                sb.push_back('{w[idx], 1'b0, 1'b0});
                idx++;
            end
            if (!rose && TXSelect) begin
                rose = 1'b1;
                t_rise = cyc;
            end
        end
        TXValid = 1'b0;
        check("accepted", idx, 6);
        check("burst_span", acc[4] - acc[0], 4);
        check("sixth_accept", acc[5] - acc[0], 154);
        for (int c = 0; c < 2000 && TXSelect; c++) @(negedge clk);
        check("frames_len", cyc - t_rise, 6 * 152);
        wait_rx(400);
        check("rx_count_lb", rx_count, 7);
        check("out_idle_burst", out_bad, 0);

        // external line: parity error, then framing error
        Loopback = 1'b0;
        repeat (4) @(negedge clk);
        sb.push_back('{16'h0001, 1'b1, 1'b0});
        send_frame(16'h0001, 1'b0, 1'b1);
        wait_rx(50);
        sb.push_back('{16'h1234, 1'b0, 1'b1});
        send_frame(16'h1234, 1'b1, 1'b0);
        wait_rx(50);
        check("rx_count_ext", rx_count, 9);

        // short low pulse is rejected, then a clean frame
        rxc = rx_count;
        ECS3_In = 1'b0;
        repeat (3) @(negedge clk);
        ECS3_In = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_rx", rx_count, rxc);
        check("glitch_idle", dut.rx_state, RX_IDLE);
        sb.push_back('{16'hFFFF, 1'b0, 1'b0});
        send_frame(16'hFFFF, 1'b0, 1'b1);
        wait_rx(50);
        check("rx_count_ffff", rx_count, rxc + 1);

        // asynchronous reset during data bit 7 of a TX frame
        rxc = rx_count;
        TXData_In = 16'h0000;
        TXValid = 1'b1;
        repeat (2) @(negedge clk);
        TXValid = 1'b0;
        repeat (74) @(negedge clk);
        check("pre_rst_line", ECS3_Out, 0);
        check("pre_rst_level", TXLevel, 1);
        nRST = 1'b0;
        #1;
        check("arst_out", ECS3_Out, 1);
        check("arst_txsel", TXSelect, 0);
        check("arst_level", TXLevel, 0);
        check("arst_ready", TXReady, 1);
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (200) @(negedge clk);
        check("post_rst_txsel", TXSelect, 0);
        check("post_rst_no_rx", rx_count, rxc);
        check("post_rst_level", TXLevel, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
